register_file_sb: RTL

//  Parametrised successor to the CPU register file, in the decode/writeback stage.
//  - Two registered read ports; one general write port.
//  - HI, LO and SR are hardware-owned registers, reloaded every cycle.
//  - BA output and SR sign flag.
//  - Per-register pending-write scoreboard so decode can stall on multi-cycle results.

---
 rtl/register_file_sb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// Parametrised decode/writeback register file with hardware-owned HI/LO/SR,
// BA tap, SR sign flag and a per-register pending-write scoreboard.
// Optional write-through forwarding into the read ports: define RF_BYPASS_EN.
module register_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int HI_IDX = 12,
  parameter int LO_IDX = 13,
  parameter int SR_IDX = 9,
  parameter int BA_IDX = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic [DATA_W-1:0] sr_in,
  output logic              sr_flag,
  output logic [DATA_W-1:0] ba_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pendingNext;

  logic              wrOk;
  logic              rsvOk;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rsvIdx;
  logic [IDX_W-1:0]  rdIdx1;
  logic [IDX_W-1:0]  rdIdx2;
  logic [DATA_W-1:0] rdSel1;
  logic [DATA_W-1:0] rdSel2;
  logic [DATA_W-1:0] baWord;
  logic              srMsb;
  logic              fwd1;
  logic              fwd2;
  logic              rsvHit1;
  logic              rsvHit2;

  // Address 0 and anything past DEPTH read as zero and never report busy.
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    return (ai != 0) && (ai < DEPTH);
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    int ai;
    ai = int'(a);
    return inRange(a) && (ai != HI_IDX) && (ai != LO_IDX) && (ai != SR_IDX);
  endfunction

  function automatic logic [IDX_W-1:0] toIdx(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  assign wrOk    = wr_en && writable(wr_addr);
  assign rsvOk   = rsv_en && writable(rsv_addr);
  assign wrIdx   = toIdx(wr_addr);
  assign rsvIdx  = toIdx(rsv_addr);
  assign rdIdx1  = toIdx(rd_addr1);
  assign rdIdx2  = toIdx(rd_addr2);
  assign rsvHit1 = rsvOk && (rsv_addr == rd_addr1);
  assign rsvHit2 = rsvOk && (rsv_addr == rd_addr2);

`ifdef RF_BYPASS_EN
  assign fwd1 = wrOk && (wr_addr == rd_addr1);
  assign fwd2 = wrOk && (wr_addr == rd_addr2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    rdSel1 = '0;
    rdSel2 = '0;
    baWord = '0;
    srMsb  = 1'b0;
    if (inRange(rd_addr1)) rdSel1 = regs[rdIdx1];
    if (inRange(rd_addr2)) rdSel2 = regs[rdIdx2];
    for (int i = 0; i < DEPTH; i++) begin
      if (i == BA_IDX) baWord = regs[i];
      if (i == SR_IDX) srMsb  = regs[i][DATA_W-1];
    end
  end

  // Set is applied after clear so a same-cycle reserve wins over the write.
  always_comb begin
    pendingNext = pending;
    if (wrOk)  pendingNext[wrIdx]  = 1'b0;
    if (rsvOk) pendingNext[rsvIdx] = 1'b1;
  end

  // A forwarded write retires the reservation the reader would otherwise see.
  assign busy1 = inRange(rd_addr1) && pending[rdIdx1] && (!fwd1 || rsvHit1);
  assign busy2 = inRange(rd_addr2) && pending[rdIdx2] && (!fwd2 || rsvHit2);

  // Storage stage: hardware-owned registers reload every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == HI_IDX)                         regs[i] <= hi_in;
        else if (i == LO_IDX)                    regs[i] <= lo_in;
        else if (i == SR_IDX)                    regs[i] <= sr_in;
        else if (wrOk && (wrIdx == IDX_W'(i)))   regs[i] <= wr_data;
      end
      pending <= pendingNext;
    end
  end

  // Output stage: reads, BA and SR flag all sample pre-update storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      sr_flag  <= 1'b0;
      ba_out   <= '0;
    end else begin
      rd_data1 <= fwd1 ? wr_data : rdSel1;
      rd_data2 <= fwd2 ? wr_data : rdSel2;
      sr_flag  <= srMsb;
      ba_out   <= baWord;
    end
  end

endmodule
